// File: rtl/uv_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uv_mem_pkg
// Description : Shared memory-subsystem types: response exception codes.
// Revision    : 1.0 - initial release
// ============================================================================
package uv_mem_pkg;

    typedef enum logic [1:0] {
        EXCP_NONE  = 2'b00,
        EXCP_RANGE = 2'b01,
        EXCP_WRITE = 2'b10
    } excp_e;

    localparam int c_EXCP_W = 2;

endpackage
`default_nettype wire

// File: rtl/uv_rom_array.sv
`default_nettype none
// ============================================================================
// Module      : uv_rom_array
// Description : Combinational constant ROM, 2**ROM_AW words of DLEN bits.
// Revision    : 1.0 - initial release
// ============================================================================
module uv_rom_array #(
    parameter int ROM_AW = 10,
    parameter int DLEN   = 32
) (
    input  logic [ROM_AW-1:0] i_addr,
    output logic [DLEN-1:0]   o_data
);

    localparam int c_WORDS = 2 ** ROM_AW;
    localparam int c_LANES = DLEN / 32;

    logic [DLEN-1:0] w_rom [c_WORDS];

    // Word i holds {~i, i} in 16-bit halves; the last word carries a byte-distinct marker.
    // Odd 32-bit lanes (wide configurations) hold the inverted pattern.
    generate
        for (genvar i = 0; i < c_WORDS; i++) begin : g_word
            localparam logic [15:0] c_I16  = 16'(i);
            localparam logic [31:0] c_WORD = (i == c_WORDS - 1) ? 32'hAABB_CCDD : {~c_I16, c_I16};
            for (genvar k = 0; k < c_LANES; k++) begin : g_lane
                if (k % 2 == 0) begin : g_even
                    assign w_rom[i][k*32 +: 32] = c_WORD;
                end else begin : g_odd
                    assign w_rom[i][k*32 +: 32] = ~c_WORD;
                end
            end
        end
    endgenerate

    assign o_data = w_rom[i_addr];

endmodule
`default_nettype wire

// File: rtl/uv_rom_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uv_rom_fifo
// Description : In-order response FIFO; head is zero whenever the FIFO is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module uv_rom_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    output logic             o_rdy,
    input  logic             i_pop,
    output logic             o_vld,
    output logic [WIDTH-1:0] o_rdata
);

    localparam int            c_PW   = $clog2(DEPTH);
    localparam logic [c_PW:0] c_FULL = (c_PW + 1)'(DEPTH);

    logic [c_PW-1:0]  r_wptr;
    logic [c_PW-1:0]  r_rptr;
    logic [c_PW:0]    r_count;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push;
    logic             w_pop;

    assign o_rdy  = (r_count < c_FULL);
    assign o_vld  = (r_count != '0);
    assign w_push = i_push & o_rdy;
    assign w_pop  = i_pop & o_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + c_PW'(1);
            if (w_pop)  r_rptr <= r_rptr + c_PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_PW + 1)'(1);
                2'b01:   r_count <= r_count - (c_PW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_wdata;
    end

    // Storage is not reset, so the head is gated to keep outputs clean while empty.
    assign o_rdata = o_vld ? r_mem[r_rptr] : '0;

endmodule
`default_nettype wire

// File: rtl/uv_rom_pipe.sv
`default_nettype none
// ============================================================================
// Module      : uv_rom_pipe
// Description : Read-only memory port with byte masking, error flagging and
//               a buffered in-order response channel.
// Revision    : 1.0 - initial release
// ============================================================================
module uv_rom_pipe
    import uv_mem_pkg::*;
#(
    parameter int ALEN   = 26,
    parameter int DLEN   = 32,
    parameter int MLEN   = DLEN / 8,
    parameter int ROM_AW = 10,
    parameter int DEPTH  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rom_req_vld,
    output logic            rom_req_rdy,
    input  logic            rom_req_read,
    input  logic [ALEN-1:0] rom_req_addr,
    input  logic [MLEN-1:0] rom_req_mask,
    input  logic [DLEN-1:0] rom_req_data,
    output logic            rom_rsp_vld,
    input  logic            rom_rsp_rdy,
    output logic [1:0]      rom_rsp_excp,
    output logic [DLEN-1:0] rom_rsp_data
);

    localparam int c_LW = $clog2(MLEN);
    localparam int c_HI = ROM_AW + c_LW;

    logic [ROM_AW-1:0] w_idx;
    logic [DLEN-1:0]   w_rom_data;
    logic [DLEN-1:0]   w_mask_bits;
    logic [DLEN-1:0]   w_data;
    logic [1:0]        w_excp;
    logic              w_range;
    logic              w_push;
    logic [DLEN+1:0]   w_head;
    logic              w_unused;

    assign w_idx  = rom_req_addr[c_HI-1:c_LW];
    assign w_push = rom_req_vld & rom_req_rdy;

    uv_rom_array #(
        .ROM_AW (ROM_AW),
        .DLEN   (DLEN)
    ) u_rom (
        .i_addr (w_idx),
        .o_data (w_rom_data)
    );

    generate
        if (ALEN > c_HI) begin : g_range
            assign w_range = |rom_req_addr[ALEN-1:c_HI];
        end else begin : g_no_range
            assign w_range = 1'b0;
        end
        for (genvar b = 0; b < MLEN; b++) begin : g_mask
            assign w_mask_bits[b*8 +: 8] = {8{rom_req_mask[b]}};
        end
    endgenerate

    // Write errors outrank range errors; any error zeroes the returned data.
    always_comb begin
        w_excp = EXCP_NONE;
        w_data = '0;
        if (!rom_req_read) begin
            w_excp = EXCP_WRITE;
        end else if (w_range) begin
            w_excp = EXCP_RANGE;
        end else begin
            w_data = w_rom_data & w_mask_bits;
        end
    end

    uv_rom_fifo #(
        .WIDTH (DLEN + 2),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata ({w_excp, w_data}),
        .o_rdy   (rom_req_rdy),
        .i_pop   (rom_rsp_rdy),
        .o_vld   (rom_rsp_vld),
        .o_rdata (w_head)
    );

    assign rom_rsp_excp = w_head[DLEN+1:DLEN];
    assign rom_rsp_data = w_head[DLEN-1:0];

    // The ROM is never written and sub-word byte offsets carry no meaning.
    assign w_unused = ^{rom_req_data, rom_req_addr[c_LW-1:0]};

endmodule
`default_nettype wire

// File: tb/tb_uv_rom_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_uv_rom_pipe
// Description : Self-checking bench for uv_rom_pipe against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uv_rom_pipe;

    localparam int ALEN   = 26;
    localparam int DLEN   = 32;
    localparam int MLEN   = 4;
    localparam int ROM_AW = 10;
    localparam int DEPTH  = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_vld;
    logic            req_rdy;
    logic            req_read;
    logic [ALEN-1:0] req_addr;
    logic [MLEN-1:0] req_mask;
    logic [DLEN-1:0] req_data;
    logic            rsp_vld;
    logic            rsp_rdy;
    logic [1:0]      rsp_excp;
    logic [DLEN-1:0] rsp_data;

    logic [DLEN+1:0] mq[$];
    logic            t_acc;
    logic            t_pop;
    int              checks = 0;
    int              errors = 0;

    always #5 clk = ~clk;

    uv_rom_pipe #(
        .ALEN   (ALEN),
        .DLEN   (DLEN),
        .MLEN   (MLEN),
        .ROM_AW (ROM_AW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rom_req_vld  (req_vld),
        .rom_req_rdy  (req_rdy),
        .rom_req_read (req_read),
        .rom_req_addr (req_addr),
        .rom_req_mask (req_mask),
        .rom_req_data (req_data),
        .rom_rsp_vld  (rsp_vld),
        .rom_rsp_rdy  (rsp_rdy),
        .rom_rsp_excp (rsp_excp),
        .rom_rsp_data (rsp_data)
    );

    // ROM image: word i = {~i, i} in 16-bit halves, last word = 0xAABBCCDD.
    function automatic logic [31:0] rom_model(input int unsigned idx);
        logic [15:0] i16;
        i16 = idx[15:0];
        if (idx == 1023) return 32'hAABB_CCDD;
        return {~i16, i16};
    endfunction

    function automatic logic [DLEN+1:0] expect_rsp(input logic rd, input logic [ALEN-1:0] addr,
                                                   input logic [MLEN-1:0] mask);
        logic [31:0] w;
        if (!rd) return {2'b10, 32'h0};
        if ((addr >> 12) != 0) return {2'b01, 32'h0};
        w = rom_model(int'(addr[11:2]));
        for (int b = 0; b < 4; b++) if (!mask[b]) w[b*8 +: 8] = 8'h00;
        return {2'b00, w};
    endfunction

    // Advance one clock, updating the model with what the interface transfers.
    task automatic tick();
        t_acc = req_vld && (mq.size() < DEPTH);
        t_pop = rsp_rdy && (mq.size() != 0);
        if (t_pop) void'(mq.pop_front());
        if (t_acc) mq.push_back(expect_rsp(req_read, req_addr, req_mask));
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic rd, input logic [ALEN-1:0] a, input logic [MLEN-1:0] m);
        req_vld  = vld;
        req_read = rd;
        req_addr = a;
        req_mask = m;
        req_data = $urandom;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (rsp_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b exp 0", rsp_vld); end
        checks++;
        if ({rsp_excp, rsp_data} !== 34'h0) begin
            errors++; $display("FAIL reset_out got %h exp 0", {rsp_excp, rsp_data});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        checks++;
        if (req_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got %b exp 1", req_rdy); end
    endtask

    task automatic test_back_to_back();
        rsp_rdy = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c < 8) drive(1'b1, 1'b1, ALEN'(c * 4), 4'hF);
            else       drive(1'b0, 1'b1, '0, 4'hF);
            if (c < 8) begin
                checks++;
                if (req_rdy !== 1'b1) begin errors++; $display("FAIL b2b_rdy c=%0d got %b exp 1", c, req_rdy); end
            end
            checks++;
            if (c >= 1 && c <= 8) begin
                if (rsp_vld !== 1'b1 || {rsp_excp, rsp_data} !== {2'b00, rom_model(c - 1)}) begin
                    errors++;
                    $display("FAIL b2b_rsp c=%0d got vld=%b %h exp %h", c, rsp_vld,
                             {rsp_excp, rsp_data}, {2'b00, rom_model(c - 1)});
                end
            end else if (rsp_vld !== 1'b0) begin
                errors++; $display("FAIL b2b_idle c=%0d got vld=%b exp 0", c, rsp_vld);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [ALEN-1:0] addrs [6];
        logic [DLEN+1:0] exp_list [6];
        int n_sent = 0;
        int n_pop  = 0;
        for (int k = 0; k < 6; k++) begin
            addrs[k]    = ALEN'($urandom_range(0, 4095));
            exp_list[k] = expect_rsp(1'b1, addrs[k], 4'hF);
        end
        rsp_rdy = 1'b0;
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, 1'b1, addrs[n_sent], 4'hF);
            checks++;
            if (req_rdy !== (c < 4)) begin errors++; $display("FAIL bp_rdy c=%0d got %b exp %b", c, req_rdy, c < 4); end
            if (c >= 1) begin
                checks++;
                if (rsp_vld !== 1'b1 || {rsp_excp, rsp_data} !== exp_list[0]) begin
                    errors++;
                    $display("FAIL bp_hold c=%0d got vld=%b %h exp %h", c, rsp_vld, {rsp_excp, rsp_data}, exp_list[0]);
                end
            end
            tick();
            if (t_acc) n_sent++;
        end
        checks++;
        if (n_sent != 4) begin errors++; $display("FAIL bp_accepted got %0d exp 4", n_sent); end
        rsp_rdy = 1'b1;
        for (int c = 0; c < 30 && n_pop < 6; c++) begin
            if (n_sent < 6) drive(1'b1, 1'b1, addrs[n_sent], 4'hF);
            else            drive(1'b0, 1'b1, '0, 4'hF);
            checks++;
            if (rsp_vld !== 1'b1 || {rsp_excp, rsp_data} !== exp_list[n_pop]) begin
                errors++;
                $display("FAIL bp_drain n=%0d got vld=%b %h exp %h", n_pop, rsp_vld, {rsp_excp, rsp_data}, exp_list[n_pop]);
            end
            tick();
            if (t_acc) n_sent++;
            if (t_pop) n_pop++;
        end
        checks++;
        if (n_pop != 6 || n_sent != 6 || rsp_vld !== 1'b0) begin
            errors++;
            $display("FAIL bp_total got pop=%0d sent=%0d vld=%b exp 6 6 0", n_pop, n_sent, rsp_vld);
        end
    endtask

    task automatic test_write_err();
        rsp_rdy = 1'b1;
        drive(1'b1, 1'b0, ALEN'(32'h10), 4'hF);
        tick();
        drive(1'b1, 1'b1, ALEN'(32'h10), 4'hF);
        checks++;
        if (rsp_vld !== 1'b1 || {rsp_excp, rsp_data} !== {2'b10, 32'h0}) begin
            errors++; $display("FAIL write_err got vld=%b %h exp 2_00000000", rsp_vld, {rsp_excp, rsp_data});
        end
        tick();
        drive(1'b0, 1'b1, '0, 4'hF);
        checks++;
        if (rsp_vld !== 1'b1 || {rsp_excp, rsp_data} !== {2'b00, 32'hFFFB_0004}) begin
            errors++; $display("FAIL write_then_read got vld=%b %h exp 0_fffb0004", rsp_vld, {rsp_excp, rsp_data});
        end
        tick();
        checks++;
        if (rsp_vld !== 1'b0) begin errors++; $display("FAIL write_drain got vld=%b exp 0", rsp_vld); end
    endtask

    task automatic test_range_err();
        logic [DLEN+1:0] exp_seq [3];
        exp_seq[0] = {2'b01, 32'h0};
        exp_seq[1] = {2'b01, 32'h0};
        exp_seq[2] = {2'b10, 32'h0};
        rsp_rdy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            case (c)
                0:       drive(1'b1, 1'b1, ALEN'(32'h1010), 4'hF);
                1:       drive(1'b1, 1'b1, ALEN'(32'h0200_0004), 4'hF);
                2:       drive(1'b1, 1'b0, ALEN'(32'h1010), 4'hF);
                default: drive(1'b0, 1'b1, '0, 4'hF);
            endcase
            if (c >= 1) begin
                checks++;
                if (rsp_vld !== 1'b1 || {rsp_excp, rsp_data} !== exp_seq[c-1]) begin
                    errors++;
                    $display("FAIL range_err c=%0d got vld=%b %h exp %h", c, rsp_vld, {rsp_excp, rsp_data}, exp_seq[c-1]);
                end
            end
            tick();
        end
    endtask

    task automatic test_mask();
        rsp_rdy = 1'b1;
        drive(1'b1, 1'b1, ALEN'(32'hFFC), 4'b0101);
        tick();
        drive(1'b1, 1'b1, ALEN'(32'h8), 4'b0000);
        checks++;
        if (rsp_vld !== 1'b1 || {rsp_excp, rsp_data} !== {2'b00, 32'h00BB_00DD}) begin
            errors++; $display("FAIL mask_0101 got vld=%b %h exp 0_00bb00dd", rsp_vld, {rsp_excp, rsp_data});
        end
        tick();
        drive(1'b0, 1'b1, '0, 4'hF);
        checks++;
        if (rsp_vld !== 1'b1 || {rsp_excp, rsp_data} !== 34'h0) begin
            errors++; $display("FAIL mask_zero got vld=%b %h exp 0_00000000", rsp_vld, {rsp_excp, rsp_data});
        end
        tick();
    endtask

    task automatic test_random();
        logic [ALEN-1:0] a;
        for (int c = 0; c < 300; c++) begin
            a = ALEN'($urandom);
            if ($urandom_range(0, 7) != 0) a[ALEN-1:12] = '0;
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, a, 4'($urandom));
            rsp_rdy = ($urandom_range(0, 2) != 0);
            checks++;
            if (req_rdy !== (mq.size() < DEPTH) || rsp_vld !== (mq.size() != 0)) begin
                errors++;
                $display("FAIL rand_flags c=%0d got rdy=%b vld=%b exp occ=%0d", c, req_rdy, rsp_vld, mq.size());
            end
            if (mq.size() != 0) begin
                checks++;
                if ({rsp_excp, rsp_data} !== mq[0]) begin
                    errors++; $display("FAIL rand_head c=%0d got %h exp %h", c, {rsp_excp, rsp_data}, mq[0]);
                end
            end
            tick();
        end
        drive(1'b0, 1'b1, '0, 4'hF);
        rsp_rdy = 1'b1;
        for (int c = 0; c < DEPTH + 2; c++) tick();
        checks++;
        if (rsp_vld !== 1'b0 || mq.size() != 0) begin
            errors++; $display("FAIL rand_drain got vld=%b exp 0 (model occ %0d)", rsp_vld, mq.size());
        end
    endtask

    task automatic test_reset_mid();
        rsp_rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b1, ALEN'(c * 4 + 32'h40), 4'hF);
            tick();
        end
        drive(1'b0, 1'b1, '0, 4'hF);
        checks++;
        if (rsp_vld !== 1'b1) begin errors++; $display("FAIL rmid_pre got vld=%b exp 1", rsp_vld); end
        rst_n = 1'b0;
        mq.delete();
        #1;
        checks++;
        if (rsp_vld !== 1'b0 || {rsp_excp, rsp_data} !== 34'h0) begin
            errors++; $display("FAIL rmid_async got vld=%b %h exp 0", rsp_vld, {rsp_excp, rsp_data});
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rsp_rdy = 1'b1;
        tick();
        checks++;
        if (req_rdy !== 1'b1 || rsp_vld !== 1'b0) begin
            errors++; $display("FAIL rmid_after got rdy=%b vld=%b exp 1 0", req_rdy, rsp_vld);
        end
        tick();
        tick();
        checks++;
        if (rsp_vld !== 1'b0) begin errors++; $display("FAIL rmid_stale got vld=%b exp 0", rsp_vld); end
    endtask

    initial begin
        drive(1'b0, 1'b1, '0, 4'hF);
        rsp_rdy = 1'b0;
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_write_err();
        test_range_err();
        test_mask();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/uv_rom_pipe.md
UV_ROM_PIPE -- requirements
Module: uv_rom_pipe

Interface
REQ-001 SHALL have parameter ALEN, default 26, request address width.
REQ-002 SHALL have parameter DLEN, default 32, data width; legal values 32, 64.
REQ-003 SHALL have parameter MLEN, default DLEN/8, byte-mask width.
REQ-004 SHALL have parameter ROM_AW, default 10, ROM word-address width.
REQ-005 SHALL have parameter DEPTH, default 4, response buffer entries; power of 2, at least 2.
REQ-006 SHALL have ports clk input 1 clock; rst_n input 1 reset (asynchronous, active-low).
REQ-007 SHALL have ports rom_req_vld in 1, rom_req_rdy out 1, rom_req_read in 1, rom_req_addr in ALEN, rom_req_mask in MLEN, rom_req_data in DLEN.
REQ-008 SHALL have ports rom_rsp_vld out 1, rom_rsp_rdy in 1, rom_rsp_excp out 2, rom_rsp_data out DLEN.

Function
REQ-009 SHALL accept a request on a cycle with rom_req_vld=1 and rom_req_rdy=1.
REQ-010 SHALL drive rom_req_rdy=1 only when the buffer holds fewer than DEPTH entries; the decision uses registered occupancy, with no same-cycle pop bypass.
REQ-011 SHALL form the word index as rom_req_addr[ROM_AW+LOG2(MLEN)-1 : LOG2(MLEN)] and ignore the low LOG2(MLEN) bits.
REQ-012 SHALL read the ROM combinationally and, for each accepted read, capture data with unselected mask bytes forced to 0.
REQ-013 SHALL flag a range error (excp=2'b01, data 0) when any rom_req_addr bit at or above ROM_AW+LOG2(MLEN) is nonzero.
REQ-014 SHALL flag a write error (excp=2'b10, data 0) when rom_req_read=0; ROM contents are never modified and rom_req_data is ignored.
REQ-015 SHALL give a write error priority over a range error.
REQ-016 SHALL treat a read with all mask bits 0 as legal: excp=2'b00, data 0.
REQ-017 SHALL push one entry {excp, data} per accepted request into an in-order FIFO, with the first response visible at cycle N+1 for acceptance at cycle N.
REQ-018 SHALL drive rom_rsp_vld=1 whenever the FIFO is non-empty, with rom_rsp_data and rom_rsp_excp taken from the head entry.
REQ-019 SHALL pop the head on rom_rsp_vld and rom_rsp_rdy both 1; head data SHALL stay stable while vld=1 and rdy=0.
REQ-020 SHALL, on a simultaneous push and pop, leave occupancy unchanged and keep both entries in order.
REQ-021 SHALL wrap read and write pointers modulo DEPTH; occupancy counter width is LOG2(DEPTH)+1.
REQ-022 SHALL never drop or duplicate a response, including under sustained rom_rsp_rdy=0.
REQ-023 SHALL sustain 1 request per cycle when rom_rsp_rdy is held at 1.

Reset
REQ-024 SHALL, while rst_n=0, force rom_rsp_vld=0, rom_rsp_excp=0, rom_rsp_data=0, occupancy=0, pointers=0, and rom_req_rdy=1 one cycle after release.
REQ-025 SHALL discard all buffered responses on reset assertion mid-operation; none are replayed after release.

Structure
REQ-026 SHALL place the exception codes (EXCP_NONE=2'b00, EXCP_RANGE=2'b01, EXCP_WRITE=2'b10) in the shared package uv_mem_pkg.
REQ-027 SHALL instantiate sub-module uv_rom_fifo (parameters WIDTH=DLEN+2, DEPTH) for response buffering.
REQ-028 SHALL instantiate ROM content as a separate combinational array sub-module parametrised by ROM_AW and DLEN.

Verification
REQ-029 SHALL cover back-to-back read: 8 reads at byte addresses 0x0..0x1C (DLEN=32) with rsp_rdy=1 -> 8 responses at N+1..N+8 with words 0..7, excp 0, req_rdy stays 1.
REQ-030 SHALL cover backpressure: rsp_rdy=0 with 6 requests at DEPTH=4 -> exactly 4 accepted, req_rdy=0 from the cycle after the 4th; raising rsp_rdy drains them in order and the remaining 2 are accepted.
REQ-031 SHALL cover write error: rom_req_read=0 at addr 0x10 -> excp=2'b10, data 0; a following read of 0x10 returns the original word.
REQ-032 SHALL cover range error: addr with bit 12 set (ROM_AW=10, DLEN=32) -> excp=2'b01, data 0.
REQ-033 SHALL cover the mask: mask=4'b0101 on a word 0xAABBCCDD -> data 0x00BB00DD.
REQ-034 SHALL cover reset mid-operation: assert rst_n=0 with 3 entries buffered -> rsp_vld=0 immediately; after release no stale response and rdy=1.
